// File: rtl/uart_cmd_responder.sv
`timescale 1ns/1ps
// Purpose : UART packet command responder; decodes register write/read packets
//           from a byte-level UART receiver and answers with one response byte.
// Latency : a byte reaches the decoder one cycle after it is captured; the
//           response leaves 3 cycles after the closing 0xEF is delivered
//           (EXEC, TX_REQ, then tx_send high), provided tx_ready is already 1.
// Backpressure: four-phase handshakes on both sides. rx_clear is held until
//           rx_valid falls. No new byte is taken while a response is pending
//           or being sent. tx_send is held until the transmitter drops
//           tx_ready.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-low reset
//   rx_data   received byte from the UART
//   rx_valid  level flag: a received byte is pending in the UART
//   rx_error  framing error for the pending byte
//   rx_clear  byte-consumed handshake back to the UART
//   tx_data   response byte to the UART transmitter
//   tx_send   transmit request, held until the transmitter goes busy
//   tx_ready  transmitter idle
//   reg_out   flattened register file; reg k at [k*WORD_LENGHT +: WORD_LENGHT]
//   busy      high whenever the command FSM is not idle
//   cmd_done  one-cycle pulse once the response byte has been transmitted
module uart_cmd_responder #(
    parameter int WORD_LENGHT    = 8,
    parameter int NUM_REGS       = 8,
    parameter int TIMEOUT_CYCLES = 5000000
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [WORD_LENGHT-1:0]          rx_data,
    input  logic                            rx_valid,
    input  logic                            rx_error,
    output logic                            rx_clear,
    output logic [WORD_LENGHT-1:0]          tx_data,
    output logic                            tx_send,
    input  logic                            tx_ready,
    output logic [NUM_REGS*WORD_LENGHT-1:0] reg_out,
    output logic                            busy,
    output logic                            cmd_done
);

    localparam int IDXW = $clog2(NUM_REGS);
    localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);

    // Protocol byte values, sized to the configured word length.
    localparam logic [WORD_LENGHT-1:0] SOF_BYTE  = WORD_LENGHT'(8'hFE);
    localparam logic [WORD_LENGHT-1:0] EOF_BYTE  = WORD_LENGHT'(8'hEF);
    localparam logic [WORD_LENGHT-1:0] CMD_WR    = WORD_LENGHT'(8'h01);
    localparam logic [WORD_LENGHT-1:0] CMD_RD    = WORD_LENGHT'(8'h02);
    localparam logic [WORD_LENGHT-1:0] RESP_ACK  = WORD_LENGHT'(8'hAA);
    localparam logic [WORD_LENGHT-1:0] RESP_NACK = WORD_LENGHT'(8'h55);
    localparam logic [WORD_LENGHT-1:0] NREGS_W   = WORD_LENGHT'(NUM_REGS);
    localparam logic [TW-1:0]          TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE,
        GET_CMD,
        GET_ADDR,
        GET_DATA,
        GET_END,
        EXEC,
        TX_REQ,
        TX_START,
        TX_DONE
    } state_t;

    state_t                 state;
    logic [WORD_LENGHT-1:0] regs [NUM_REGS];

    // Captured byte and its one-cycle delivery strobe.
    logic                   byte_vld;
    logic [WORD_LENGHT-1:0] byte_dat;
    logic                   byte_err;

    // Packet fields collected while decoding.
    logic                   is_write;
    logic [WORD_LENGHT-1:0] addr_q;
    logic [WORD_LENGHT-1:0] data_q;
    logic [WORD_LENGHT-1:0] resp;

    logic [TW-1:0]          tmo_cnt;

    logic                   rx_accept;
    logic                   in_pkt;
    logic                   tmo_hit;
    logic [IDXW-1:0]        addr_idx;

    // New bytes are only accepted while idle or mid-packet; during EXEC and
    // the transmit phase a pending byte is left in the UART until IDLE.
    assign in_pkt    = (state == GET_CMD) || (state == GET_ADDR) ||
                       (state == GET_DATA) || (state == GET_END);
    assign rx_accept = (state == IDLE) || in_pkt;
    assign tmo_hit   = (tmo_cnt == TMO_LAST);
    assign addr_idx  = addr_q[IDXW-1:0];

    always_comb begin
        reg_out = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            reg_out[k*WORD_LENGHT +: WORD_LENGHT] = regs[k];
        end
    end

    // Receive handshake. A byte is latched when rx_valid is seen with
    // rx_clear low; rx_clear then stays high until the UART withdraws
    // rx_valid, so each UART byte is delivered exactly once regardless of
    // how slowly the UART responds. A handshake already in progress is
    // always completed, even if the FSM has moved on to EXEC/TX.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_clear <= 1'b0;
            byte_vld <= 1'b0;
            byte_dat <= '0;
            byte_err <= 1'b0;
        end else begin
            byte_vld <= 1'b0;
            if (!rx_clear) begin
                if (rx_valid && rx_accept) begin
                    byte_dat <= rx_data;
                    byte_err <= rx_error;
                    rx_clear <= 1'b1;
                    byte_vld <= 1'b1;
                end
            end else if (!rx_valid) begin
                rx_clear <= 1'b0;
            end
        end
    end

    // Command FSM, register file, inter-byte timeout and transmit handshake.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            cmd_done <= 1'b0;
            tx_send  <= 1'b0;
            tx_data  <= '0;
            tmo_cnt  <= '0;
            is_write <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            resp     <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            cmd_done <= 1'b0;

            // Counts idle cycles between packet bytes; any delivered byte
            // restarts the window.
            if (byte_vld || !in_pkt) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    // Noise and errored bytes are silently dropped while
                    // hunting for a start-of-packet.
                    if (byte_vld && !byte_err && (byte_dat == SOF_BYTE)) begin
                        state <= GET_CMD;
                        busy  <= 1'b1;
                    end
                end

                GET_CMD: begin
                    if (byte_vld) begin
                        if (!byte_err && ((byte_dat == CMD_WR) || (byte_dat == CMD_RD))) begin
                            is_write <= (byte_dat == CMD_WR);
                            state    <= GET_ADDR;
                        end else begin
                            resp  <= RESP_NACK;
                            state <= TX_REQ;
                        end
                    end else if (tmo_hit) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                GET_ADDR: begin
                    if (byte_vld) begin
                        if (byte_err) begin
                            resp  <= RESP_NACK;
                            state <= TX_REQ;
                        end else begin
                            addr_q <= byte_dat;
                            state  <= is_write ? GET_DATA : GET_END;
                        end
                    end else if (tmo_hit) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                GET_DATA: begin
                    if (byte_vld) begin
                        if (byte_err) begin
                            resp  <= RESP_NACK;
                            state <= TX_REQ;
                        end else begin
                            data_q <= byte_dat;
                            state  <= GET_END;
                        end
                    end else if (tmo_hit) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                GET_END: begin
                    if (byte_vld) begin
                        if (!byte_err && (byte_dat == EOF_BYTE)) begin
                            state <= EXEC;
                        end else begin
                            resp  <= RESP_NACK;
                            state <= TX_REQ;
                        end
                    end else if (tmo_hit) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                EXEC: begin
                    // Full address byte is range-checked so out-of-range
                    // addresses never alias onto a real register.
                    if (addr_q >= NREGS_W) begin
                        resp <= RESP_NACK;
                    end else if (is_write) begin
                        regs[addr_idx] <= data_q;
                        resp           <= RESP_ACK;
                    end else begin
                        resp <= regs[addr_idx];
                    end
                    state <= TX_REQ;
                end

                TX_REQ: begin
                    if (tx_ready) begin
                        tx_data <= resp;
                        tx_send <= 1'b1;
                        state   <= TX_START;
                    end
                end

                TX_START: begin
                    // Transmitter acknowledges by going busy.
                    if (!tx_ready) begin
                        tx_send <= 1'b0;
                        state   <= TX_DONE;
                    end
                end

                TX_DONE: begin
                    if (tx_ready) begin
                        cmd_done <= 1'b1;
                        state    <= IDLE;
                        busy     <= 1'b0;
                    end
                end

                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    tx_send <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_responder.sv
`timescale 1ns/1ps
module tb_uart_cmd_responder;

    localparam int WL = 8;
    localparam int NR = 8;
    localparam int TO = 300;

    logic             clk = 1'b0;
    logic             rst;
    logic [WL-1:0]    rx_data;
    logic             rx_valid;
    logic             rx_error;
    logic             rx_clear;
    logic [WL-1:0]    tx_data;
    logic             tx_send;
    logic             tx_ready;
    logic [NR*WL-1:0] reg_out;
    logic             busy;
    logic             cmd_done;

    always #5 clk = ~clk;

    uart_cmd_responder #(
        .WORD_LENGHT   (WL),
        .NUM_REGS      (NR),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .rx_error(rx_error),
        .rx_clear(rx_clear),
        .tx_data (tx_data),
        .tx_send (tx_send),
        .tx_ready(tx_ready),
        .reg_out (reg_out),
        .busy    (busy),
        .cmd_done(cmd_done)
    );

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mregs[NR];

    function automatic logic [NR*WL-1:0] model_vec();
        logic [NR*WL-1:0] v;
        v = '0;
        for (int k = 0; k < NR; k++) v[k*WL +: WL] = mregs[k];
        return v;
    endfunction

    // ---------------- UART receiver emulation ----------------
    task automatic present_byte(input logic [7:0] b, input logic e);
        int t;
        t = 0;
        while (rx_clear !== 1'b0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) begin
            n_cmp++; n_err++;
            $display("FAIL rx_idle_wait: rx_clear=%b required 0", rx_clear);
        end
        rx_data  = b;
        rx_error = e;
        rx_valid = 1'b1;
    endtask

    task automatic finish_byte(input int hold, output bit held_ok);
        int t;
        t = 0;
        held_ok = 1'b1;
        while (rx_clear !== 1'b1 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) begin
            n_cmp++; n_err++;
            $display("FAIL rx_take_wait: rx_clear=%b required 1", rx_clear);
            held_ok = 1'b0;
        end
        repeat (hold) begin
            @(negedge clk);
            if (rx_clear !== 1'b1) held_ok = 1'b0;
        end
        rx_valid = 1'b0;
        rx_error = 1'b0;
        @(negedge clk);
        if (rx_clear !== 1'b0) held_ok = 1'b0;
    endtask

    // Byte i of the packet is pkt[39-8*i -: 8]; emask[i] flags its error bit.
    task automatic send_pkt(input logic [39:0] pkt, input int n,
                            input logic [4:0] emask, input int hold,
                            output bit held_all);
        bit h;
        logic [7:0] b;
        held_all = 1'b1;
        for (int i = 0; i < n; i++) begin
            b = pkt[39-8*i -: 8];
            present_byte(b, emask[i]);
            finish_byte(hold, h);
            if (!h) held_all = 1'b0;
        end
    endtask

    // ---------------- UART transmitter emulation ----------------
    // Waits for tx_send, goes busy lat cycles later, stays busy busy_cyc
    // cycles, then returns idle and counts cmd_done pulses. clr_hi counts
    // cycles with rx_clear high before cmd_done appears.
    task automatic tx_capture(input int lat, input int busy_cyc,
                              output logic [7:0] got, output bit held_ok,
                              output int done_cnt, output int clr_hi);
        int t;
        t = 0;
        got = 8'hxx;
        held_ok = 1'b1;
        done_cnt = 0;
        clr_hi = 0;
        while (tx_send !== 1'b1 && t < 3000) begin
            @(negedge clk);
            t++;
            if (rx_clear === 1'b1) clr_hi++;
        end
        if (t >= 3000) begin
            n_cmp++; n_err++;
            $display("FAIL tx_send_wait: tx_send=%b required 1", tx_send);
            held_ok = 1'b0;
        end else begin
            got = tx_data;
            repeat (lat) begin
                @(negedge clk);
                if (tx_send !== 1'b1 || tx_data !== got) held_ok = 1'b0;
                if (rx_clear === 1'b1) clr_hi++;
            end
            tx_ready = 1'b0;
            @(negedge clk);
            if (tx_send !== 1'b0) held_ok = 1'b0;
            repeat (busy_cyc) begin
                @(negedge clk);
                if (rx_clear === 1'b1) clr_hi++;
                if (cmd_done === 1'b1) done_cnt++;
            end
            tx_ready = 1'b1;
            repeat (4) begin
                @(negedge clk);
                if (done_cnt == 0 && rx_clear === 1'b1) clr_hi++;
                if (cmd_done === 1'b1) done_cnt++;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0; rx_valid = 1'b0; rx_error = 1'b0; rx_data = '0; tx_ready = 1'b1;
        for (int k = 0; k < NR; k++) mregs[k] = 8'h00;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({rx_clear, tx_send, busy, cmd_done} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b required 0000", {rx_clear, tx_send, busy, cmd_done});
        end
        n_cmp++;
        if (tx_data !== 8'h00) begin
            n_err++; $display("FAIL reset_tx_data: got %h required 00", tx_data);
        end
        n_cmp++;
        if (reg_out !== '0) begin
            n_err++; $display("FAIL reset_regs: got %h required 0", reg_out);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write();
        logic [7:0] got, e; bit h; int dc, ch;
        mregs[3] = 8'h5A; exp_q.push_back(8'hAA);
        send_pkt({8'hFE, 8'h01, 8'h03, 8'h5A, 8'hEF}, 5, 5'b0, 0, h);
        tx_capture(2, 10, got, h, dc, ch);
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin n_err++; $display("FAIL write_resp: got %h required %h", got, e); end
        n_cmp++;
        if (reg_out[31:24] !== 8'h5A) begin
            n_err++; $display("FAIL write_reg3: got %h required 5a", reg_out[31:24]);
        end
        n_cmp++;
        if (reg_out !== model_vec()) begin
            n_err++; $display("FAIL write_regs: got %h required %h", reg_out, model_vec());
        end
        n_cmp++;
        if (dc != 1) begin n_err++; $display("FAIL write_cmd_done: got %0d pulses required 1", dc); end
    endtask

    task automatic test_read();
        logic [7:0] got, e; bit h; int dc, ch;
        exp_q.push_back(mregs[3]);
        send_pkt({8'hFE, 8'h02, 8'h03, 8'hEF, 8'h00}, 4, 5'b0, 0, h);
        tx_capture(3, 8, got, h, dc, ch);
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin n_err++; $display("FAIL read_resp: got %h required %h", got, e); end
        n_cmp++;
        if (reg_out !== model_vec()) begin
            n_err++; $display("FAIL read_regs: got %h required %h", reg_out, model_vec());
        end
        n_cmp++;
        if (dc != 1) begin n_err++; $display("FAIL read_cmd_done: got %0d pulses required 1", dc); end
    endtask

    task automatic test_errors();
        logic [7:0] got, e; bit h; int dc, ch;
        exp_q.push_back(8'h55);
        send_pkt({8'hFE, 8'h07, 24'h0}, 2, 5'b0, 0, h);
        tx_capture(1, 5, got, h, dc, ch);
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin n_err++; $display("FAIL bad_cmd: got %h required %h", got, e); end

        exp_q.push_back(8'h55);
        send_pkt({8'hFE, 8'h01, 8'h09, 8'h11, 8'hEF}, 5, 5'b0, 0, h);
        tx_capture(1, 5, got, h, dc, ch);
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin n_err++; $display("FAIL bad_addr: got %h required %h", got, e); end
        n_cmp++;
        if (reg_out !== model_vec()) begin
            n_err++; $display("FAIL bad_addr_regs: got %h required %h", reg_out, model_vec());
        end

        exp_q.push_back(8'h55);
        send_pkt({8'hFE, 8'h02, 8'h01, 8'h00, 8'h00}, 4, 5'b0, 0, h);
        tx_capture(1, 5, got, h, dc, ch);
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin n_err++; $display("FAIL bad_end: got %h required %h", got, e); end
    endtask

    task automatic test_framing();
        logic [7:0] got, e; bit h; int dc, ch;
        // Noise byte and an errored start byte must both be ignored in IDLE.
        send_pkt({8'h33, 32'h0}, 1, 5'b0, 0, h);
        send_pkt({8'hFE, 32'h0}, 1, 5'b00001, 0, h);
        exp_q.push_back(mregs[0]);
        send_pkt({8'hFE, 8'h02, 8'h00, 8'hEF, 8'h00}, 4, 5'b0, 0, h);
        tx_capture(2, 6, got, h, dc, ch);
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin n_err++; $display("FAIL noise_ignored: got %h required %h", got, e); end

        exp_q.push_back(8'h55);
        send_pkt({8'hFE, 8'h02, 8'h03, 16'h0}, 3, 5'b00100, 0, h);
        tx_capture(2, 6, got, h, dc, ch);
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin n_err++; $display("FAIL addr_frame_err: got %h required %h", got, e); end
    endtask

    task automatic test_fe_as_data();
        logic [7:0] got, e; bit h; int dc, ch;
        mregs[5] = 8'hFE; exp_q.push_back(8'hAA);
        send_pkt({8'hFE, 8'h01, 8'h05, 8'hFE, 8'hEF}, 5, 5'b0, 0, h);
        tx_capture(1, 5, got, h, dc, ch);
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin n_err++; $display("FAIL fe_data_resp: got %h required %h", got, e); end
        n_cmp++;
        if (reg_out !== model_vec()) begin
            n_err++; $display("FAIL fe_data_regs: got %h required %h", reg_out, model_vec());
        end

        exp_q.push_back(8'h55);
        send_pkt({8'hFE, 8'h02, 8'hFE, 8'hEF, 8'h00}, 4, 5'b0, 0, h);
        tx_capture(1, 5, got, h, dc, ch);
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin n_err++; $display("FAIL fe_addr_resp: got %h required %h", got, e); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got, e; bit h; int dc, ch;
        exp_q.push_back(mregs[5]);
        send_pkt({8'hFE, 8'h02, 8'h05, 8'hEF, 8'h00}, 4, 5'b0, 0, h);
        // Next packet's start byte is already pending while the response goes out.
        present_byte(8'hFE, 1'b0);
        tx_capture(3, 12, got, h, dc, ch);
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin n_err++; $display("FAIL b2b_first: got %h required %h", got, e); end
        n_cmp++;
        if (ch != 0) begin n_err++; $display("FAIL b2b_no_take: rx_clear high %0d cycles required 0", ch); end
        finish_byte(0, h);
        exp_q.push_back(mregs[3]);
        send_pkt({8'h02, 8'h03, 8'hEF, 16'h0}, 3, 5'b0, 0, h);
        tx_capture(1, 5, got, h, dc, ch);
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin n_err++; $display("FAIL b2b_second: got %h required %h", got, e); end
    endtask

    task automatic test_timeout();
        logic [7:0] got, e; bit h; int dc, ch, seen;
        send_pkt({8'hFE, 8'h01, 24'h0}, 2, 5'b0, 0, h);
        seen = 0;
        repeat (TO - 20) begin @(negedge clk); if (tx_send === 1'b1) seen++; end
        n_cmp++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL tmo_early: busy=%b required 1", busy); end
        repeat (40) begin @(negedge clk); if (tx_send === 1'b1) seen++; end
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL tmo_idle: busy=%b required 0", busy); end
        n_cmp++;
        if (seen != 0) begin n_err++; $display("FAIL tmo_no_tx: tx_send high %0d cycles required 0", seen); end

        mregs[2] = 8'hC3; exp_q.push_back(8'hAA);
        send_pkt({8'hFE, 8'h01, 8'h02, 8'hC3, 8'hEF}, 5, 5'b0, 0, h);
        tx_capture(1, 5, got, h, dc, ch);
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin n_err++; $display("FAIL tmo_recover: got %h required %h", got, e); end
        n_cmp++;
        if (reg_out !== model_vec()) begin
            n_err++; $display("FAIL tmo_regs: got %h required %h", reg_out, model_vec());
        end
    endtask

    task automatic test_stress();
        logic [7:0] got, e; bit h, hall; int dc, ch;
        mregs[7] = 8'h99; exp_q.push_back(8'hAA);
        send_pkt({8'hFE, 8'h01, 8'h07, 8'h99, 8'hEF}, 5, 5'b0, 40, hall);
        n_cmp++;
        if (!hall) begin n_err++; $display("FAIL rx_hold: held=%b required 1", hall); end
        tx_capture(100, 20, got, h, dc, ch);
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin n_err++; $display("FAIL stress_resp: got %h required %h", got, e); end
        n_cmp++;
        if (!h) begin n_err++; $display("FAIL tx_hold: held=%b required 1", h); end
        n_cmp++;
        if (reg_out !== model_vec()) begin
            n_err++; $display("FAIL stress_regs: got %h required %h", reg_out, model_vec());
        end
        n_cmp++;
        if (dc != 1) begin n_err++; $display("FAIL stress_cmd_done: got %0d pulses required 1", dc); end
    endtask

    task automatic test_reset_mid_tx();
        logic [7:0] got, e; bit h; int dc, ch, t, seen;
        send_pkt({8'hFE, 8'h02, 8'h03, 8'hEF, 8'h00}, 4, 5'b0, 0, h);
        t = 0;
        while (tx_send !== 1'b1 && t < 200) begin @(negedge clk); t++; end
        n_cmp++;
        if (tx_send !== 1'b1) begin n_err++; $display("FAIL rst_tx_start: tx_send=%b required 1", tx_send); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({tx_send, busy} !== 2'b00) begin
            n_err++; $display("FAIL rst_tx_drop: got %b required 00", {tx_send, busy});
        end
        n_cmp++;
        if (reg_out !== '0) begin n_err++; $display("FAIL rst_regs: got %h required 0", reg_out); end
        rst = 1'b1;
        for (int k = 0; k < NR; k++) mregs[k] = 8'h00;
        seen = 0;
        repeat (50) begin @(negedge clk); if (tx_send === 1'b1) seen++; end
        n_cmp++;
        if (seen != 0) begin n_err++; $display("FAIL rst_no_resp: tx_send high %0d cycles required 0", seen); end

        exp_q.push_back(mregs[3]);
        send_pkt({8'hFE, 8'h02, 8'h03, 8'hEF, 8'h00}, 4, 5'b0, 0, h);
        tx_capture(2, 5, got, h, dc, ch);
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin n_err++; $display("FAIL rst_recover: got %h required %h", got, e); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_errors();
        test_framing();
        test_fe_as_data();
        test_back_to_back();
        test_timeout();
        test_stress();
        test_reset_mid_tx();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL scoreboard_drain: %0d left required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
